// File: rtl/demux14_sched.sv
// Round-robin 1:4 dispatcher: buffers one word from a valid/ready producer and
// presents it on a shared bus with a one-hot valid toward the chosen sink.
module demux14_sched #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       en,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [1:0]       sel,
   output logic             busy,
   output logic [CNTW-1:0]  cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             deliver;
   logic             accept;

   // First enabled sink at or after base; scanning downward lets the lowest offset win.
   function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] mask);
      logic [1:0] cand;
      rr_pick = base;
      for (int i = 3; i >= 0; i--) begin
         cand = base + 2'(i);
         if (mask[cand]) rr_pick = cand;
      end
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d  = state_q;
      sel_d    = sel_q;
      buf_d    = buf_q;
      deliver  = (state_q == SEND) && out_ready[sel_q];
      cnt_d    = cnt_q + {{(CNTW-1){1'b0}}, deliver};
      ptr_d    = deliver ? sel_q + 2'd1 : ptr_q;
      in_ready = rst_n && (|en) && ((state_q == IDLE) || deliver);
      accept   = in_valid && in_ready;

      // The reload pick uses the already-advanced pointer so back-to-back words rotate.
      if (accept) begin
         buf_d   = in_data;
         sel_d   = rr_pick(ptr_d, en);
         state_d = SEND;
      end else if (deliver) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q == SEND);
   assign out_valid = busy ? (4'b0001 << sel_q) : 4'b0000;
   assign out_data  = buf_q;
   assign sel       = sel_q;
   assign cnt       = cnt_q;

endmodule

// File: doc/demux14_sched.md
# demux14_sched

Round-robin dispatcher that sequences the 1:4 demultiplexer path: accepts a word stream on one valid/ready input and delivers each word to exactly one of four sinks (a..d = index 0..3). It holds one word in a buffer, picks the destination by round-robin over an enable mask, and drives the shared data bus plus a one-hot valid. It sits between a single producer and four consumers that share the demux output bus.

## Interface
- WIDTH, 8, data word width in bits
- CNTW, 16, width of the delivered-word counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  input word
- in_valid  in  1  producer has a word
- in_ready  out  1  dispatcher accepts a word this cycle
- en  in  4  destination enable mask; bit k = sink k may receive
- out_data  out  WIDTH  shared output bus, buffered word
- out_valid  out  4  one-hot; bit k = word on out_data is for sink k
- out_ready  in  4  bit k = sink k accepts this cycle
- sel  out  2  destination index of the held word
- busy  out  1  a word is held (state SEND)
- cnt  out  CNTW  count of words delivered, wraps modulo 2^CNTW

## Operation
- States: IDLE (buffer empty), SEND (buffer holds one word for destination sel).
- Round-robin pointer ptr (2 bits): candidate order ptr, ptr+1, ptr+2, ptr+3 (mod 4); destination = first candidate with en bit set.
- IDLE: in_ready = |en. On in_valid & in_ready: buffer <= in_data, sel <= RR pick, go SEND. en == 0: in_ready = 0, stay IDLE.
- SEND: out_valid = one-hot(sel), out_data = buffer, busy = 1. Delivery = out_ready[sel]; out_ready of other bits ignored.
- On delivery: cnt <= cnt+1; ptr <= sel+1 (mod 4).
  - If in_valid & in_ready same cycle (in_ready = out_ready[sel] & |en): reload buffer, new sel = RR pick using updated ptr, stay SEND (back-to-back, 1 word/cycle).
  - Else go IDLE, out_valid <= 0.
- No delivery in SEND: buffer, sel, out_valid held stable; in_ready = 0.
- en changed while in SEND: held word still delivered to latched sel, even if en[sel] now 0; en only affects later picks.
- Words never dropped or duplicated; in-order delivery overall.
- out_data outside SEND: holds last buffered value (don't-care for sinks).

## Timing
- Reset (rst_n low, asynchronous): state IDLE, ptr 0, sel 0, buffer/out_data 0, out_valid 0000, busy 0, cnt 0; in_ready forced 0 while rst_n low.
- Reset mid-SEND: held word discarded, outputs at reset values immediately.
- Latency: word accepted at edge N appears with out_valid at edge N (registered), visible cycle N..N+1; earliest delivery on edge N+1.
- Throughput: 1 word/cycle when chosen sinks are ready; a word waiting in SEND never blocks more than until its sink asserts out_ready.
- Handshake: out_valid/out_data/sel stable from assertion until delivery edge; in_ready is combinational from state, en, out_ready.
- cnt wrap: 2^CNTW-1 + 1 -> 0.

## Test plan
- Reset: rst_n low mid-stream -> out_valid=0000, in_ready=0, cnt=0, sel=0 same cycle; after release with en=1111, in_ready=1.
- Round robin: en=1111, out_ready=1111, send 0x11,0x22,0x33,0x44,0x55 back-to-back -> delivered to sinks 0,1,2,3,0 on consecutive cycles, cnt=5.
- Mask skip: en=1010, out_ready=1111, send 5 words -> sinks 1,3,1,3,1; out_valid never 0001/0100.
- Backpressure: en=1111, out_ready=0000 for 4 cycles after accepting 0xA5 -> out_valid=0001, out_data=0xA5 stable, in_ready=0; raise out_ready[0] -> delivered, cnt+1, next word goes to sink 1.
- Mask change while held: word 0x5A held for sink 2, en set 0000 -> still delivered on out_ready[2]; then in_ready=0, state IDLE.
- Counter wrap: CNTW=4, deliver 17 words -> cnt=1.
